// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  typedef logic [31:0] pc_t;
  typedef logic [31:0] instr_t;

  typedef struct packed {
    pc_t    pc;
    instr_t instr;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  localparam instr_t INSTR_NOP = 32'h0000_0013;
  localparam pc_t    PC_STEP   = 32'd4;

  function automatic logic is_aligned(input pc_t pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO holding {pc, instr} pairs returned by instruction memory.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr;
  logic         rd_ptr;

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem_q[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch initiator: issues addresses to instruction memory, buffers returned words
// and hands {pc, instr} to decode; redirects flush everything, misaligned ones halt.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter pc_t RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_imem_pc,
  input  logic [31:0] i_imem_instr,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_fault
);

  localparam logic [0:0] ST_RUN  = RUN;
  localparam logic [0:0] ST_HALT = HALT;

  logic [0:0]   state;
  pc_t          fetch_pc;
  pc_t          inflight_pc;
  logic         inflight;
  logic         fault_q;
  logic [1:0]   buf_count;
  fetch_entry_t head_entry;
  fetch_entry_t push_entry;
  logic         pop;
  logic         push;
  logic         issue;
  logic [2:0]   credit;

  assign pop    = o_valid & i_ready;
  // Slots already committed after this cycle's pop; at most two may be outstanding.
  assign credit = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue  = (state == ST_RUN) && (credit < 3'd2);
  assign push   = inflight & ~i_redirect;

  assign push_entry.pc    = inflight_pc;
  assign push_entry.instr = i_imem_instr;

  // Issue stage: fetch_pc is presented to memory, the response arrives next cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      state    <= ST_RUN;
      fault_q  <= 1'b0;
    end else if (i_redirect) begin
      inflight <= 1'b0;
      fetch_pc <= {i_redirect_pc[31:2], 2'b00};
      if (is_aligned(i_redirect_pc)) begin
        state   <= ST_RUN;
        fault_q <= 1'b0;
      end else begin
        state   <= ST_HALT;
        fault_q <= 1'b1;
      end
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (issue) begin
      inflight_pc <= fetch_pc;
    end
  end

  // Response stage: returned word joins its address in the buffer.
  fetch_buf u_buf (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (i_redirect),
    .count     (buf_count),
    .head      (head_entry)
  );

  assign o_imem_pc = fetch_pc;
  assign o_valid   = (buf_count != 2'd0) & ~i_redirect;
  assign o_instr   = head_entry.instr;
  assign o_pc      = head_entry.pc;
  assign o_fault   = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by random ready/redirect/reset
// traffic, all judged by an expected-stream scoreboard.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        fault;

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_imem_pc     (imem_pc),
    .i_imem_instr  (imem_instr),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_instr       (instr),
    .o_pc          (pc),
    .o_fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[31:16] ^ a[15:0], a[15:0]} ^ 32'h9E37_79B9;
  endfunction

  // Synchronous-read instruction memory
  always @(posedge clk) imem_instr <= memword(imem_pc);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: next pc decode must see, fault flag, halted fetch address,
  // and how long the output has been empty since the last restart.
  logic [31:0] exp_pc    = RESET_PC;
  logic        m_fault   = 1'b0;
  logic [31:0] m_halt_pc = 32'h0;
  int          streak    = 0;
  bit          seen      = 1'b0;
  bit          post_rst  = 1'b0;

  always @(negedge clk) begin
    if (post_rst) begin
      chk("rst_valid", {31'b0, valid}, 32'd0);
      chk("rst_imem_pc", imem_pc, RESET_PC);
      chk("rst_instr", instr, 32'd0);
      chk("rst_pc", pc, 32'd0);
      chk("rst_fault", {31'b0, fault}, 32'd0);
      post_rst = 1'b0;
    end
    if (!rst_n) begin
      exp_pc   = RESET_PC;
      m_fault  = 1'b0;
      streak   = 0;
      seen     = 1'b0;
      post_rst = 1'b1;
    end else begin
      chk("fault", {31'b0, fault}, {31'b0, m_fault});
      if (redirect) begin
        chk("redir_valid", {31'b0, valid}, 32'd0);
        if (redirect_pc[1:0] == 2'b00) begin
          exp_pc  = redirect_pc;
          m_fault = 1'b0;
        end else begin
          m_fault   = 1'b1;
          m_halt_pc = redirect_pc & 32'hFFFF_FFFC;
        end
        streak = 0;
        seen   = 1'b0;
      end else if (m_fault) begin
        chk("halt_valid", {31'b0, valid}, 32'd0);
        chk("halt_imem_pc", imem_pc, m_halt_pc);
      end else if (valid) begin
        if (!seen) chk("latency", streak, 32'd2);
        seen = 1'b1;
        chk("head_pc", pc, exp_pc);
        chk("head_instr", instr, memword(exp_pc));
        if (ready) exp_pc = exp_pc + 32'd4;
      end else if (seen || streak >= 2) begin
        chk("stream_valid", {31'b0, valid}, 32'd1);
      end else begin
        streak++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect    = 1'b1;
    redirect_pc = tgt;
    step(1);
    redirect = 1'b0;
  endtask

  logic [31:0] frz;
  logic [31:0] tgt;
  int          r;

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    ready       = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(12);

    // stall: fetch address must freeze once the buffer is full
    ready = 1'b0;
    step(2);
    frz = imem_pc;
    step(3);
    chk("stall_imem_pc", imem_pc, frz);
    ready = 1'b1;
    step(6);

    // redirect with a full buffer and a fetch in flight
    ready = 1'b0;
    step(3);
    ready = 1'b1;
    do_redirect(32'h0000_0100);
    step(6);

    do_redirect(32'h0000_0102);
    step(4);
    chk("misaligned_imem_pc", imem_pc, 32'h0000_0100);
    chk("misaligned_fault", {31'b0, fault}, 32'd1);
    do_redirect(32'h0000_0200);
    step(6);

    do_redirect(32'hFFFF_FFF8);
    step(8);

    // reset with a full buffer
    ready = 1'b0;
    step(3);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    ready = 1'b1;
    step(10);

    for (int i = 0; i < 3000; i++) begin
      ready    = ($urandom_range(0, 9) < 7);
      r        = $urandom_range(0, 199);
      rst_n    = (r != 0);
      redirect = (r >= 1 && r < 11);
      tgt      = $urandom;
      case ($urandom_range(0, 4))
        0:       tgt = tgt;
        1:       tgt = 32'hFFFF_FFF0 | (tgt & 32'h0000_000C);
        default: tgt = tgt & 32'hFFFF_FFFC;
      endcase
      redirect_pc = tgt;
      step(1);
    end
    rst_n    = 1'b1;
    redirect = 1'b0;
    step(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
